// File: rtl/interp_filter_pkg.sv
// rtl/interp_filter_pkg.sv - shared constants, FSM states and coefficient ROM for interp_filter
package interp_filter_pkg;

  localparam int IDATA_WIDTH_DEF    = 16;
  localparam int COEFF_WIDTH_DEF    = 16;
  localparam int OUT_WIDTH_DEF      = 16;
  localparam int FIR_TAP_DEF        = 32;
  localparam int INTERP_DEF         = 4;
  localparam int TAPS_PER_PHASE_DEF = FIR_TAP_DEF / INTERP_DEF;
  localparam int COEFF_IDX_W        = $clog2(FIR_TAP_DEF);

  // Round half up before dropping the Q1.15 fraction.
  localparam int RND_SHIFT = COEFF_WIDTH_DEF - 1;
  localparam int RND_CONST = 1 << (COEFF_WIDTH_DEF - 2);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  // Symmetric prototype: h[n] == h[31-n]; every polyphase branch sums to 32768.
  function automatic logic signed [COEFF_WIDTH_DEF-1:0] coeff(input logic [COEFF_IDX_W-1:0] idx);
    logic [COEFF_IDX_W-2:0] m;
    m = idx[COEFF_IDX_W-1] ? ~idx[COEFF_IDX_W-2:0] : idx[COEFF_IDX_W-2:0];
    case (m)
      4'd0:  coeff = -16'sd40;
      4'd1:  coeff = -16'sd80;
      4'd2:  coeff = -16'sd150;
      4'd3:  coeff = -16'sd200;
      4'd4:  coeff = -16'sd300;
      4'd5:  coeff = -16'sd350;
      4'd6:  coeff = -16'sd100;
      4'd7:  coeff = 16'sd500;
      4'd8:  coeff = 16'sd2000;
      4'd9:  coeff = 16'sd3000;
      4'd10: coeff = 16'sd4500;
      4'd11: coeff = 16'sd6000;
      4'd12: coeff = 16'sd9000;
      4'd13: coeff = 16'sd11000;
      4'd14: coeff = 16'sd14948;
      default: coeff = 16'sd15808;
    endcase
  endfunction

endpackage

// File: rtl/interp_phase_mac.sv
// rtl/interp_phase_mac.sv - one polyphase branch: parallel multiplies, adder tree, enabled result register
module interp_phase_mac
  import interp_filter_pkg::*;
#(
  parameter int IDATA_WIDTH    = IDATA_WIDTH_DEF,
  parameter int COEFF_WIDTH    = COEFF_WIDTH_DEF,
  parameter int TAPS_PER_PHASE = TAPS_PER_PHASE_DEF,
  parameter int INTERP         = INTERP_DEF,
  parameter int PHASE_W        = 2,
  parameter int ACC_W          = 35
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [PHASE_W-1:0]                        phase,
  input  logic [TAPS_PER_PHASE-1:0][IDATA_WIDTH-1:0] taps,
  output logic signed [ACC_W-1:0]                   acc
);

  localparam int PROD_W = IDATA_WIDTH + COEFF_WIDTH;

  logic signed [ACC_W-1:0] sum;

  // Branch `phase` uses every INTERP-th coefficient starting at h[phase].
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      sum = sum + ACC_W'(PROD_W'($signed(taps[k]))
                       * PROD_W'(coeff(COEFF_IDX_W'(phase) + COEFF_IDX_W'(INTERP * k))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/interp_filter.sv
// rtl/interp_filter.sv - 4x polyphase interpolating FIR; INTERP_FILTER_SAT_EN enables output clamping
module interp_filter
  import interp_filter_pkg::*;
#(
  parameter int IDATA_WIDTH = IDATA_WIDTH_DEF,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int FIR_TAP     = FIR_TAP_DEF,
  parameter int INTERP      = INTERP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDATA_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int TAPS_PER_PHASE = FIR_TAP / INTERP;
  localparam int PHASE_W        = $clog2(INTERP);
  localparam int ACC_W          = IDATA_WIDTH + COEFF_WIDTH + $clog2(TAPS_PER_PHASE);

`ifdef INTERP_FILTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_WIDTH - 1)));

  state_t                                     state_q, state_d;
  logic [PHASE_W-1:0]                         phase_q, phase_d;
  logic [TAPS_PER_PHASE-1:0][IDATA_WIDTH-1:0] taps_q;
  logic                                       shift;
  logic                                       mac_en;
  logic signed [ACC_W-1:0]                    acc;
  logic signed [ACC_W-1:0]                    rounded;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    shift   = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift   = 1'b1;
          phase_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        mac_en  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (phase_q == PHASE_W'(INTERP - 1)) begin
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      taps_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (shift) begin
        taps_q <= {taps_q[TAPS_PER_PHASE-2:0], in_data};
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);

  interp_phase_mac #(
    .IDATA_WIDTH    (IDATA_WIDTH),
    .COEFF_WIDTH    (COEFF_WIDTH),
    .TAPS_PER_PHASE (TAPS_PER_PHASE),
    .INTERP         (INTERP),
    .PHASE_W        (PHASE_W),
    .ACC_W          (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (mac_en),
    .phase (phase_q),
    .taps  (taps_q),
    .acc   (acc)
  );

  // out_data is a pure function of the held accumulator, so it stays stable through HOLD.
  assign rounded = (acc + ACC_W'(RND_CONST)) >>> RND_SHIFT;

  always_comb begin
    out_data = rounded[OUT_WIDTH-1:0];
    if (SAT_EN && (rounded > SAT_MAX)) begin
      out_data = SAT_MAX[OUT_WIDTH-1:0];
    end else if (SAT_EN && (rounded < SAT_MIN)) begin
      out_data = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_interp_filter.sv
// tb/tb_interp_filter.sv - self-checking bench for interp_filter against a zero-stuffed convolution model
module tb_interp_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  int h_tab [32] = '{
    -40, -80, -150, -200, -300, -350, -100, 500,
    2000, 3000, 4500, 6000, 9000, 11000, 14948, 15808,
    15808, 14948, 11000, 9000, 6000, 4500, 3000, 2000,
    500, -100, -350, -300, -200, -150, -80, -40
  };

  logic signed [15:0] hist[$];
  logic [15:0]        obs [4];

  interp_filter dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Output m = 4n+p of the zero-stuffed input convolved with h, rounded half up.
  function automatic logic [15:0] model_out(input int p);
    longint acc;
    longint r;
    int     n;
    acc = 0;
    n   = hist.size() - 1;
    for (int j = p; j < 32; j += 4) begin
      int idx;
      idx = n - j / 4;
      if (idx >= 0) acc += longint'(hist[idx]) * longint'(h_tab[j]);
    end
    r = (acc + 16384) >>> 15;
`ifdef INTERP_FILTER_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic push(input logic [15:0] x, input int stall_p, input int rst_p);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data  = x;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    hist.push_back(x);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    for (int p = 0; p < 4; p++) begin
      cnt = 0;
      while (!out_valid && cnt < 10) begin
        step();
        cnt++;
      end
      check("valid_latency", cnt, 32'd1);
      check("in_ready_hold", {31'd0, in_ready}, 32'd0);
      obs[p] = out_data;
      check("out_data", {16'd0, out_data}, {16'd0, model_out(p)});
      if (p == rst_p) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        hist.delete();
        return;
      end
      if (p == stall_p) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        for (int c = 0; c < 5; c++) begin
          step();
          check("stall_data", {16'd0, out_data}, {16'd0, obs[p]});
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      step();
    end
    check("in_ready_return", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic impulse_run(input bit stalled);
    for (int n = 0; n < 9; n++) begin
      push((n == 0) ? 16'sd32767 : 16'sd0, stalled ? (n % 4) : -1, -1);
      for (int p = 0; p < 4; p++) begin
        check("impulse_h", {16'd0, obs[p]}, (n < 8) ? 32'(h_tab[4 * n + p]) & 32'hFFFF : 32'd0);
      end
    end
  endtask

  initial begin
    int diff;
    logic [15:0] x;

    step();
    step();
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {16'd0, out_data}, 32'd0);
    rst = 1'b0;
    step();

    impulse_run(1'b0);

    for (int n = 0; n < 20; n++) begin
      push(16'd1000, -1, -1);
      if (n >= 7) begin
        for (int p = 0; p < 4; p++) begin
          diff = int'($signed(obs[p])) - 1000;
          check("dc_within_1", {31'd0, (diff <= 1 && diff >= -1)}, 32'd1);
        end
      end
    end

    for (int n = 0; n < 8; n++) push(16'd0, -1, -1);
    impulse_run(1'b1);

    for (int i = 0; i < 8; i++) begin
      x = (h_tab[1 + 4 * (7 - i)] < 0) ? 16'h8001 : 16'h7FFF;
      push(x, -1, -1);
    end
`ifdef INTERP_FILTER_SAT_EN
    check("sat_phase1", {16'd0, obs[1]}, 32'h7FFF);
`endif

    for (int n = 0; n < 24; n++) begin
      x = 16'($urandom);
      push(x, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    push(16'd1234, -1, 2);
    impulse_run(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
